cache_port_arbiter: RTL and testbench

- Shares the single two-way data cache port between the instruction-fetch requester (port 0, read-only) and the load/store requester (port 1).
- Round-robin arbitration with valid/ready handshake on each requester.
- Sequences each access through hit check, optional dirty write-back wait and RAM refill wait, then returns read data with a one-cycle rvalid pulse.
- Sits between the pipeline memory stages and the cache top; the stall conditions for the pipeline are derived from its ready outputs.

---
 rtl/cache_port_arbiter_pkg.sv | 21 ++
 rtl/cache_port_arbiter_if.sv | 33 +++
 rtl/cache_port_arbiter_rr.sv | 25 ++
 rtl/cache_port_arbiter.sv | 111 +++++++++++
 tb/tb_cache_port_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_port_arbiter_pkg.sv
// cache_arb_pkg: shared types and constants for cache_port_arbiter.
//   state_t  : access sequencer states
//   req_t    : latched request (addr, wd, we, addr_mode, port)
//   sat_inc  : saturating increment used by the optional performance counters
package cache_arb_pkg;
    // Request fields are ARB_DW wide; the arbiter is instantiated with DATA_WIDTH == ARB_DW.
    localparam int ARB_DW = 32;
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;
    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, REPLAY, RESP} state_t;
    typedef struct packed {
        logic [ARB_DW-1:0] addr;
        logic [ARB_DW-1:0] wd;
        logic              we;
        logic              addr_mode;
        logic              port;
    } req_t;
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return v + 32'(v != '1);
    endfunction
endpackage

// File: rtl/cache_port_arbiter_if.sv
// cache_port_arbiter_if: requester handshakes and cache-side bus of cache_port_arbiter.
//   master : requesters and cache (drive req0_*/req1_* requests, c_rd, c_hit, c_evict)
//   slave  : the arbiter (drives ready/rvalid/rdata, c_en/c_addr/c_wd/c_we/c_addr_mode, ram_busy)
//   CACHE_ARB_PERF_EN adds hit_count, miss_count, wb_count (arbiter outputs).
interface cache_port_arbiter_if #(parameter int DATA_WIDTH = 32);
    logic                  req0_valid, req0_ready, req0_rvalid;
    logic [DATA_WIDTH-1:0] req0_addr, req0_rdata;
    logic                  req1_valid, req1_we, req1_addr_mode, req1_ready, req1_rvalid;
    logic [DATA_WIDTH-1:0] req1_addr, req1_wd, req1_rdata;
    logic                  c_en, c_we, c_addr_mode, c_hit, c_evict, ram_busy;
    logic [DATA_WIDTH-1:0] c_addr, c_wd, c_rd;
`ifdef CACHE_ARB_PERF_EN
    logic [31:0]           hit_count, miss_count, wb_count;
`endif
    modport master (
        output req0_valid, req0_addr, req1_valid, req1_we, req1_addr_mode, req1_addr, req1_wd,
               c_rd, c_hit, c_evict,
        input  req0_ready, req0_rvalid, req0_rdata, req1_ready, req1_rvalid, req1_rdata,
               c_en, c_addr, c_wd, c_we, c_addr_mode, ram_busy
`ifdef CACHE_ARB_PERF_EN
        , input hit_count, miss_count, wb_count
`endif
    );
    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_we, req1_addr_mode, req1_addr, req1_wd,
               c_rd, c_hit, c_evict,
        output req0_ready, req0_rvalid, req0_rdata, req1_ready, req1_rvalid, req1_rdata,
               c_en, c_addr, c_wd, c_we, c_addr_mode, ram_busy
`ifdef CACHE_ARB_PERF_EN
        , output hit_count, miss_count, wb_count
`endif
    );
endinterface

// File: rtl/cache_port_arbiter_rr.sv
// cache_arb_rr: two-way round-robin grant with last-granted pointer.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> port 0)
//   valid_i    : request valids {port1, port0}
//   en_i       : arbitration enabled; the pointer moves to the granted port when a grant is issued
//   grant_o    : one-hot combinational grant
module cache_arb_rr
    import cache_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    input  logic       en_i,
    output logic [1:0] grant_o
);
    logic ptr_q, ptr_d;
    // Under contention the port that did not win last time is favoured.
    always_comb begin
        grant_o[1] = valid_i[1] & (!valid_i[0] | ptr_q == PORT_FETCH);
        grant_o[0] = valid_i[0] & (!valid_i[1] | ptr_q == PORT_DATA);
        ptr_d      = (en_i & |valid_i) ? grant_o[1] : ptr_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= PORT_FETCH;
        else        ptr_q <= ptr_d;
endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: shares one cache port between fetch (port 0) and load/store (port 1).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cache_port_arbiter_if.slave -- requester handshakes, c_* cache strobes, ram_busy
//   Each accepted access runs LOOKUP, optional WRITEBACK/REFILL/REPLAY, then a one-cycle rvalid in RESP.
//   CACHE_ARB_PERF_EN adds saturating hit/miss/write-back counters on the interface.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = ARB_DW,
    parameter int RAM_LATENCY = 4,
    parameter int WB_LATENCY  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_port_arbiter_if.slave  bus
);
    localparam int CW = $clog2(RAM_LATENCY > WB_LATENCY ? RAM_LATENCY : WB_LATENCY) + 1;
    localparam logic [CW-1:0] RAM_LOAD = CW'(RAM_LATENCY - 1);
    localparam logic [CW-1:0] WB_LOAD  = CW'(WB_LATENCY - 1);
    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    req_t                    req_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              grant;
    logic                    idle, cache_cyc, resp;
`ifdef CACHE_ARB_PERF_EN
    logic [31:0]             hit_q, miss_q, wb_q;
    assign bus.hit_count  = hit_q;
    assign bus.miss_count = miss_q;
    assign bus.wb_count   = wb_q;
`endif
    assign idle      = state_q == IDLE;
    assign cache_cyc = state_q == LOOKUP || state_q == REPLAY;
    assign resp      = state_q == RESP;
    cache_arb_rr u_rr (
        .clk,
        .rst_n,
        .valid_i ({bus.req1_valid, bus.req0_valid}),
        .en_i    (idle),
        .grant_o (grant)
    );
    // Ready is masked by rst_n so every output reads 0 while reset is asserted.
    assign bus.req0_ready  = rst_n & idle & grant[0];
    assign bus.req1_ready  = rst_n & idle & grant[1];
    assign bus.req0_rvalid = resp & req_q.port == PORT_FETCH;
    assign bus.req1_rvalid = resp & req_q.port == PORT_DATA;
    assign bus.req0_rdata  = bus.req0_rvalid ? rdata_q : '0;
    assign bus.req1_rdata  = bus.req1_rvalid ? rdata_q : '0;
    assign bus.c_en        = cache_cyc;
    assign bus.c_addr      = cache_cyc ? DATA_WIDTH'(req_q.addr) : '0;
    assign bus.c_wd        = cache_cyc ? DATA_WIDTH'(req_q.wd) : '0;
    assign bus.c_we        = cache_cyc & req_q.we;
    assign bus.c_addr_mode = cache_cyc & req_q.addr_mode;
    assign bus.ram_busy    = state_q == WRITEBACK || state_q == REFILL;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
`ifdef CACHE_ARB_PERF_EN
            hit_q   <= '0;
            miss_q  <= '0;
            wb_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (|grant) begin
                    req_q   <= grant[1] ? '{addr: ARB_DW'(bus.req1_addr), wd: ARB_DW'(bus.req1_wd),
                                            we: bus.req1_we, addr_mode: bus.req1_addr_mode, port: PORT_DATA}
                                        : '{addr: ARB_DW'(bus.req0_addr), wd: '0,
                                            we: 1'b0, addr_mode: 1'b0, port: PORT_FETCH};
                    state_q <= LOOKUP;
                end
                LOOKUP: begin
`ifdef CACHE_ARB_PERF_EN
                    if (bus.c_hit) hit_q <= sat_inc(hit_q);
                    else           miss_q <= sat_inc(miss_q);
                    if (!bus.c_hit && bus.c_evict) wb_q <= sat_inc(wb_q);
`endif
                    if (bus.c_hit) begin
                        rdata_q <= req_q.we ? '0 : bus.c_rd;
                        state_q <= RESP;
                    end else if (bus.c_evict) begin
                        cnt_q   <= WB_LOAD;
                        state_q <= WRITEBACK;
                    end else begin
                        cnt_q   <= RAM_LOAD;
                        state_q <= REFILL;
                    end
                end
                WRITEBACK: if (cnt_q == '0) begin
                    cnt_q   <= RAM_LOAD;
                    state_q <= REFILL;
                end else cnt_q <= cnt_q - CW'(1);
                REFILL: if (cnt_q == '0) state_q <= REPLAY;
                        else             cnt_q   <= cnt_q - CW'(1);
                // A replay miss means the refill did not install the word; wait for another refill.
                REPLAY: if (bus.c_hit) begin
                    rdata_q <= req_q.we ? '0 : bus.c_rd;
                    state_q <= RESP;
                end else begin
                    cnt_q   <= RAM_LOAD;
                    state_q <= REFILL;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: self-checking bench for cache_port_arbiter (vector table, directed sequences, random vs. model).
module tb_cache_port_arbiter;
    localparam int RAM_LAT = 4;
    localparam int WB_LAT  = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    cache_port_arbiter_if #(.DATA_WIDTH(32)) bus();
    cache_port_arbiter #(.DATA_WIDTH(32), .RAM_LATENCY(RAM_LAT), .WB_LATENCY(WB_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    // Cache environment: plan 0 hit, 1 clean miss, 2 dirty miss; any access after the first lookup hits.
    logic [1:0]  plan = 2'd0;
    logic        seen_en;
    logic        rd_ovr_en = 1'b0;
    logic [31:0] rd_ovr = 32'h0;
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction
    always_comb begin
        bus.c_rd    = rd_ovr_en ? rd_ovr : mem_word(bus.c_addr);
        bus.c_hit   = bus.c_en & (plan == 2'd0 | seen_en);
        bus.c_evict = bus.c_en & plan == 2'd2 & !seen_en;
    end
    always @(posedge clk or negedge rst_n)
        if (!rst_n) seen_en <= 1'b0;
        else if (bus.req0_ready | bus.req1_ready) seen_en <= 1'b0;
        else if (bus.c_en) seen_en <= 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [8:0] all_out();
        return {bus.req0_ready, bus.req0_rvalid, bus.req1_ready, bus.req1_rvalid, bus.c_en, bus.c_we,
                bus.c_addr_mode, bus.ram_busy,
                |{bus.req0_rdata, bus.req1_rdata, bus.c_addr, bus.c_wd}};
    endfunction

    task automatic do_reset();
        bus.req0_valid = 0; bus.req0_addr = 0;
        bus.req1_valid = 0; bus.req1_we = 0; bus.req1_addr_mode = 0; bus.req1_addr = 0; bus.req1_wd = 0;
        plan = 0; rd_ovr_en = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // One access from idle: checks acceptance, latency, ram_busy length, cache strobes and data.
    task automatic run_one(input string name, input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] p, input int exp_lat,
                           input int exp_busy, input logic [31:0] exp_data);
        int lat, busy, ens;
        logic strobe_ok, other;
        logic [31:0] data;
        plan = p;
        if (port) begin
            bus.req1_valid = 1; bus.req1_we = we; bus.req1_addr = addr; bus.req1_wd = wd; bus.req1_addr_mode = 0;
        end else begin
            bus.req0_valid = 1; bus.req0_addr = addr;
        end
        @(negedge clk);
        check($sformatf("%s_ready", name), port ? bus.req1_ready : bus.req0_ready, 1);
        @(posedge clk); #1;
        bus.req0_valid = 0; bus.req1_valid = 0;
        lat = -1; busy = 0; ens = 0; strobe_ok = 1; other = 0; data = 0;
        for (int t = 1; t <= 40 && lat < 0; t++) begin
            @(negedge clk);
            busy += int'(bus.ram_busy);
            ens  += int'(bus.c_en);
            if (bus.c_en && (bus.c_we !== we || bus.c_addr !== addr || (we && bus.c_wd !== wd))) strobe_ok = 0;
            if (port ? bus.req0_rvalid : bus.req1_rvalid) other = 1;
            if (port ? bus.req1_rvalid : bus.req0_rvalid) begin
                lat  = t;
                data = port ? bus.req1_rdata : bus.req0_rdata;
            end
            @(posedge clk); #1;
        end
        check($sformatf("%s_latency", name), lat, exp_lat);
        check($sformatf("%s_ram_busy_cycles", name), busy, exp_busy);
        check($sformatf("%s_c_en_cycles", name), ens, p == 0 ? 1 : 2);
        check($sformatf("%s_rdata", name), data, exp_data);
        check($sformatf("%s_strobes", name), {strobe_ok, other}, 2'b10);
        @(negedge clk);
        check($sformatf("%s_pulse_end", name), {bus.req0_rvalid, bus.req1_rvalid}, 0);
        @(posedge clk); #1;
    endtask

    typedef struct packed {
        logic [1:0] v;     // {req1_valid, req0_valid}
        logic [1:0] plan;
        logic [1:0] rdy;   // {req1_ready, req0_ready}
        logic [1:0] rv;    // {req1_rvalid, req0_rvalid}
        logic       busy;
    } vec_t;
    vec_t tbl [19];

    logic        m_busy, m_ptr, m_port, g, s_r0, s_r1;
    int          m_acc, m_lat, h_n, mi_n, w_n;
    logic [31:0] m_data;
    logic [1:0]  e_rdy, e_rv;
    logic        e_busy;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Contention with all hits from reset, then a clean miss on port 1.
        tbl[0]  = '{2'b11, 2'd0, 2'b10, 2'b00, 1'b0};
        tbl[1]  = '{2'b11, 2'd0, 2'b00, 2'b00, 1'b0};
        tbl[2]  = '{2'b11, 2'd0, 2'b00, 2'b10, 1'b0};
        tbl[3]  = '{2'b11, 2'd0, 2'b01, 2'b00, 1'b0};
        tbl[4]  = '{2'b11, 2'd0, 2'b00, 2'b00, 1'b0};
        tbl[5]  = '{2'b11, 2'd0, 2'b00, 2'b01, 1'b0};
        tbl[6]  = '{2'b11, 2'd0, 2'b10, 2'b00, 1'b0};
        tbl[7]  = '{2'b11, 2'd0, 2'b00, 2'b00, 1'b0};
        tbl[8]  = '{2'b11, 2'd0, 2'b00, 2'b10, 1'b0};
        tbl[9]  = '{2'b00, 2'd0, 2'b00, 2'b00, 1'b0};
        tbl[10] = '{2'b10, 2'd1, 2'b10, 2'b00, 1'b0};
        tbl[11] = '{2'b00, 2'd1, 2'b00, 2'b00, 1'b0};
        tbl[12] = '{2'b00, 2'd1, 2'b00, 2'b00, 1'b1};
        tbl[13] = '{2'b00, 2'd1, 2'b00, 2'b00, 1'b1};
        tbl[14] = '{2'b00, 2'd1, 2'b00, 2'b00, 1'b1};
        tbl[15] = '{2'b00, 2'd1, 2'b00, 2'b00, 1'b1};
        tbl[16] = '{2'b00, 2'd1, 2'b00, 2'b00, 1'b0};
        tbl[17] = '{2'b00, 2'd1, 2'b00, 2'b10, 1'b0};
        tbl[18] = '{2'b00, 2'd1, 2'b00, 2'b00, 1'b0};
        #2;
        do_reset();
        check("reset_outputs", all_out(), 0);
        bus.req0_addr = 32'h100; bus.req1_addr = 32'h2004;
        for (int i = 0; i < 19; i++) begin
            bus.req0_valid = tbl[i].v[0]; bus.req1_valid = tbl[i].v[1]; plan = tbl[i].plan;
            @(negedge clk);
            check($sformatf("vec%0d_ctrl", i),
                  {bus.req1_ready, bus.req0_ready, bus.req1_rvalid, bus.req0_rvalid, bus.ram_busy},
                  {tbl[i].rdy, tbl[i].rv, tbl[i].busy});
            check($sformatf("vec%0d_rdata", i), {bus.req1_rdata, bus.req0_rdata},
                  {tbl[i].rv[1] ? mem_word(32'h2004) : 32'h0, tbl[i].rv[0] ? mem_word(32'h100) : 32'h0});
            @(posedge clk); #1;
        end

        rd_ovr_en = 1; rd_ovr = 32'hDEAD_BEEF;
        run_one("fetch_hit", 1'b0, 1'b0, 32'h100, 32'h0, 2'd0, 2, 0, 32'hDEAD_BEEF);
        rd_ovr_en = 0;
        run_one("clean_miss", 1'b1, 1'b0, 32'h2004, 32'h0, 2'd1, 3 + RAM_LAT, RAM_LAT, mem_word(32'h2004));
        run_one("dirty_store", 1'b1, 1'b1, 32'h3008, 32'h55, 2'd2, 3 + WB_LAT + RAM_LAT, WB_LAT + RAM_LAT, 32'h0);

        // Reset in the middle of a refill drops the access and silences every output.
        begin
            int rv0, rv1;
            plan = 1; bus.req1_valid = 1; bus.req1_we = 0; bus.req1_addr = 32'h2004;
            @(negedge clk);
            check("rst_mid_accept", bus.req1_ready, 1);
            @(posedge clk); #1 bus.req1_valid = 0;
            repeat (3) @(negedge clk);
            check("rst_mid_in_refill", bus.ram_busy, 1);
            bus.req0_valid = 1; bus.req0_addr = 32'h300;
            #2 rst_n = 0;
            #1 check("rst_mid_outputs", all_out(), 0);
            @(posedge clk); @(posedge clk); #1;
            bus.req0_valid = 0; plan = 0; rst_n = 1;
            @(posedge clk); #1 bus.req0_valid = 1;
            @(negedge clk);
            check("rst_release_ready0", bus.req0_ready, 1);
            @(posedge clk); #1 bus.req0_valid = 0;
            rv0 = 0; rv1 = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                rv0 += int'(bus.req0_rvalid);
                rv1 += int'(bus.req1_rvalid);
            end
            check("rst_dropped_rvalid", {rv0, rv1}, {32'd1, 32'd0});
            @(posedge clk); #1;
        end

        do_reset();
        for (int i = 0; i < 3; i++)
            run_one($sformatf("perf_hit%0d", i), 1'b0, 1'b0, 32'h40 + 32'(i * 4), 32'h0, 2'd0, 2, 0,
                    mem_word(32'h40 + 32'(i * 4)));
        run_one("perf_clean", 1'b1, 1'b0, 32'h80, 32'h0, 2'd1, 3 + RAM_LAT, RAM_LAT, mem_word(32'h80));
        run_one("perf_dirty", 1'b0, 1'b0, 32'hC0, 32'h0, 2'd2, 3 + WB_LAT + RAM_LAT, WB_LAT + RAM_LAT, mem_word(32'hC0));
`ifdef CACHE_ARB_PERF_EN
        check("perf_counts", {bus.hit_count, bus.miss_count, bus.wb_count}, {32'd3, 32'd2, 32'd1});
`endif

        // Random traffic against a transaction-level model: grant rule, latency formula, one outstanding access.
        do_reset();
        m_busy = 0; m_ptr = 0; m_port = 0; m_acc = 0; m_lat = 0; m_data = 0; h_n = 0; mi_n = 0; w_n = 0;
        for (int t = 0; t < 600; t++) begin
            if (!bus.req0_valid && $urandom_range(0, 2) == 0) begin
                bus.req0_valid = 1; bus.req0_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!bus.req1_valid && $urandom_range(0, 2) == 0) begin
                bus.req1_valid = 1; bus.req1_we = 1'($urandom); bus.req1_addr_mode = 1'($urandom);
                bus.req1_addr = $urandom; bus.req1_wd = $urandom;
            end
            if (!m_busy) plan = 2'($urandom_range(0, 2));
            @(negedge clk);
            e_rdy = 0;
            if (!m_busy && (bus.req0_valid || bus.req1_valid)) begin
                g = (bus.req0_valid && bus.req1_valid) ? !m_ptr : bus.req1_valid;
                e_rdy[g] = 1; m_ptr = g; m_port = g; m_busy = 1; m_acc = t;
                m_lat  = plan == 0 ? 2 : plan == 1 ? 3 + RAM_LAT : 3 + WB_LAT + RAM_LAT;
                m_data = (g && bus.req1_we) ? 32'h0 : mem_word(g ? bus.req1_addr : bus.req0_addr);
                h_n  += int'(plan == 0);
                mi_n += int'(plan != 0);
                w_n  += int'(plan == 2);
            end
            e_rv   = (m_busy && t == m_acc + m_lat) ? (m_port ? 2'b10 : 2'b01) : 2'b00;
            e_busy = m_busy && plan != 0 && t >= m_acc + 2 && t <= m_acc + m_lat - 2;
            check($sformatf("rand%0d", t),
                  {bus.req1_ready, bus.req0_ready, bus.req1_rvalid, bus.req0_rvalid, bus.ram_busy,
                   bus.req1_rdata, bus.req0_rdata},
                  {e_rdy, e_rv, e_busy, e_rv[1] ? m_data : 32'h0, e_rv[0] ? m_data : 32'h0});
            if (e_rv != 0) m_busy = 0;
            s_r0 = bus.req0_ready; s_r1 = bus.req1_ready;
            @(posedge clk); #1;
            if (s_r0) bus.req0_valid = 0;
            if (s_r1) bus.req1_valid = 0;
        end
`ifdef CACHE_ARB_PERF_EN
        check("rand_perf_counts", {bus.hit_count, bus.miss_count, bus.wb_count}, {32'(h_n), 32'(mi_n), 32'(w_n)});
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
